// File: rtl/interrupt_controller_if.sv
// interrupt_controller_if: bus address/strobe and CPU request handshake shared by the controller and its master
//   addr        bus address
//   we          bus write enable
//   cpu_irq     interrupt request to the processor
//   cpu_irq_ack processor acknowledge
interface interrupt_controller_if;
    logic [7:0] addr;
    logic       we;
    logic       cpu_irq;
    logic       cpu_irq_ack;
    modport master (output addr, output we, output cpu_irq_ack, input cpu_irq);
    modport slave  (input addr, input we, input cpu_irq_ack, output cpu_irq);
endinterface

// File: rtl/interrupt_controller.sv
// interrupt_controller: edge-captured pending/mask interrupt controller with a raise/ack request to the processor
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   bus       slave side of addr/we and the cpu_irq/cpu_irq_ack handshake
//   bus_data  shared 8-bit data bus, driven only in the cycle after a decoded read
//   src_irq   per-peripheral raise lines
//   src_ack   per-peripheral one-cycle acknowledge pulses
// Registers at BASE_ADDR+0 PENDING (W1C), +1 MASK (RW), +2 VECTOR (RO, 8'hFF when idle).
// Define INTC_ROUND_ROBIN_EN for round-robin selection; otherwise lowest index wins.
module interrupt_controller #(
    parameter int         NUM_SRC   = 4,
    parameter logic [7:0] BASE_ADDR = 8'hE0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    interrupt_controller_if.slave bus,
    inout  wire  [7:0]           bus_data,
    input  logic [NUM_SRC-1:0]   src_irq,
    output logic [NUM_SRC-1:0]   src_ack
);
    localparam logic [7:0] VALID = 8'((9'd1 << NUM_SRC) - 9'd1);
    typedef enum logic {IDLE, REQ} state_t;
    state_t state, state_d;
    logic [NUM_SRC-1:0] src_q, ack_d;
    logic [7:0] pending, pending_d, mask, mask_d, vector, vector_d;
    logic [7:0] active, sel, clr, rd_data, rd_data_d;
    logic rd_oe, rd_oe_d, fire, hit_pend, hit_mask, hit_vec;
    assign hit_pend = bus.addr == BASE_ADDR;
    assign hit_mask = bus.addr == BASE_ADDR + 8'd1;
    assign hit_vec = bus.addr == BASE_ADDR + 8'd2;
    assign active = pending & mask;
    assign bus.cpu_irq = state == REQ;
    assign bus_data = rd_oe ? rd_data : 8'hzz;
`ifdef INTC_ROUND_ROBIN_EN
    logic [7:0] last;
    logic [2:0] j;
    // Walk candidates from the farthest offset down so the nearest one after the last serviced source wins.
    always_comb begin
        sel = 8'h00;
        j = 3'd0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            j = 3'((int'(last) + 1 + k) % NUM_SRC);
            if (active[j]) sel = 8'(j);
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) last <= 8'(NUM_SRC - 1);
        else if (fire) last <= vector;
    end
`else
    always_comb begin
        sel = 8'h00;
        for (int i = 7; i >= 0; i--) if (active[i]) sel = 8'(i);
    end
`endif
    always_comb begin
        state_d = state;
        vector_d = vector;
        fire = 1'b0;
        if (state == IDLE) begin
            if (|active) begin
                state_d = REQ;
                vector_d = sel;
            end
        end else if (bus.cpu_irq_ack) begin
            fire = 1'b1;
            state_d = IDLE;
            vector_d = 8'hFF;
        end
    end
    // A fresh rising edge is OR-ed in after the clears so a same-cycle set wins over W1C or ack.
    always_comb begin
        ack_d = '0;
        for (int i = 0; i < NUM_SRC; i++) ack_d[i] = fire && vector == 8'(i);
        clr = ((bus.we && hit_pend) ? bus_data : 8'h00) | 8'(ack_d);
        pending_d = ((pending & ~clr) | 8'(src_irq & ~src_q)) & VALID;
        mask_d = (bus.we && hit_mask) ? bus_data & VALID : mask;
        rd_oe_d = !bus.we && (hit_pend || hit_mask || hit_vec);
        rd_data_d = hit_pend ? pending : hit_mask ? mask : vector;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            src_q <= '0;
            pending <= 8'h00;
            mask <= 8'h00;
            vector <= 8'hFF;
            src_ack <= '0;
            rd_oe <= 1'b0;
            rd_data <= 8'h00;
        end else begin
            state <= state_d;
            src_q <= src_irq;
            pending <= pending_d;
            mask <= mask_d;
            vector <= vector_d;
            src_ack <= ack_d;
            rd_oe <= rd_oe_d;
            rd_data <= rd_data_d;
        end
    end
endmodule

// File: tb/tb_interrupt_controller.sv
// tb_interrupt_controller: directed and randomized checks of interrupt_controller against a behavioural model
module tb_interrupt_controller;
    localparam int N = 4;
    localparam logic [7:0] BASE = 8'hE0;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [N-1:0] src_irq = '0;
    logic [N-1:0] src_ack;
    logic drv = 1'b0;
    logic [7:0] drv_val = 8'h00;
    wire [7:0] bus_data;
    int checks = 0;
    int failures = 0;
    logic [7:0] m_pend, m_mask, m_prev;
    int m_svc, m_last;
    interrupt_controller_if bus();
    interrupt_controller #(.NUM_SRC(N), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .bus_data(bus_data),
        .src_irq(src_irq), .src_ack(src_ack)
    );
    assign bus_data = drv ? drv_val : 8'hzz;
    always #5 clk = ~clk;
    initial begin
        #1000000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end
    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    task automatic model_reset();
        m_pend = 8'h00;
        m_mask = 8'h00;
        m_prev = 8'h00;
        m_svc = -1;
        m_last = N - 1;
    endtask
    // One clock: predict from the inputs presented before the edge, then compare just after it.
    task automatic step();
        logic [7:0] rise, clr, act, n_pend, n_mask, a, rd, cur;
        logic [N-1:0] n_ack;
        logic rdv;
        int n_svc, idx;
        a = bus.addr;
        cur = 8'(src_irq);
        rise = cur & ~m_prev;
        clr = (bus.we && a == BASE) ? drv_val : 8'h00;
        n_svc = m_svc;
        n_ack = '0;
        if (m_svc >= 0) begin
            if (bus.cpu_irq_ack) begin
                n_ack[m_svc] = 1'b1;
                clr[m_svc] = 1'b1;
                m_last = m_svc;
                n_svc = -1;
            end
        end else begin
            act = m_pend & m_mask;
            for (int k = 0; k < N; k++) begin
`ifdef INTC_ROUND_ROBIN_EN
                idx = (m_last + 1 + k) % N;
`else
                idx = k;
`endif
                if (act[idx] && n_svc < 0) n_svc = idx;
            end
        end
        rdv = !bus.we && a >= BASE && a <= BASE + 8'd2;
        rd = (a == BASE) ? m_pend : (a == BASE + 8'd1) ? m_mask : (m_svc < 0 ? 8'hFF : 8'(m_svc));
        n_pend = (m_pend & ~clr) | rise;
        n_mask = (bus.we && a == BASE + 8'd1) ? (drv_val & 8'h0F) : m_mask;
        @(posedge clk);
        #1;
        m_pend = n_pend;
        m_mask = n_mask;
        m_prev = cur;
        m_svc = n_svc;
        chk("cpu_irq", 8'(bus.cpu_irq), 8'(m_svc >= 0));
        chk("src_ack", 8'(src_ack), 8'(n_ack));
        if (rdv) chk("bus_rdata", bus_data, rd);
        else chk("bus_oe", 8'(dut.rd_oe), 8'h00);
    endtask
    task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
        bus.addr = a;
        bus.we = 1'b1;
        drv = 1'b1;
        drv_val = d;
        step();
        bus.we = 1'b0;
        drv = 1'b0;
        bus.addr = 8'h00;
    endtask
    task automatic bus_read(input string tag, input logic [7:0] a, input logic [7:0] exp);
        bus.addr = a;
        bus.we = 1'b0;
        step();
        bus.addr = 8'h00;
        chk(tag, bus_data, exp);
        step();
    endtask
    task automatic service();
        bus.cpu_irq_ack = 1'b1;
        step();
        bus.cpu_irq_ack = 1'b0;
    endtask
    initial begin
        bus.addr = 8'h00;
        bus.we = 1'b0;
        bus.cpu_irq_ack = 1'b0;
        model_reset();
        rst_n = 1'b0;
        src_irq = 4'hF;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_cpu_irq", 8'(bus.cpu_irq), 8'h00);
        chk("reset_src_ack", 8'(src_ack), 8'h00);
        chk("reset_bus_oe", 8'(dut.rd_oe), 8'h00);
        rst_n = 1'b1;
        bus_read("reset_pending", BASE, 8'h00);
        bus_read("reset_mask", BASE + 8'd1, 8'h00);
        bus_read("reset_vector", BASE + 8'd2, 8'hFF);
        chk("reset_no_irq_masked", 8'(bus.cpu_irq), 8'h00);
        src_irq = 4'h0;
        bus_write(BASE, 8'h0F);
        bus_read("pending_w1c_all", BASE, 8'h00);
        bus_write(BASE + 8'd1, 8'h01);
        src_irq = 4'b0001;
        step();
        chk("timer_irq_n1", 8'(bus.cpu_irq), 8'h00);
        step();
        chk("timer_irq_n2", 8'(bus.cpu_irq), 8'h01);
        bus_read("timer_vector", BASE + 8'd2, 8'h00);
        service();
        chk("timer_ack_pulse", 8'(src_ack), 8'h01);
        chk("timer_irq_drop", 8'(bus.cpu_irq), 8'h00);
        step();
        chk("timer_ack_one_cycle", 8'(src_ack), 8'h00);
        bus_read("timer_pending_clear", BASE, 8'h00);
        src_irq = 4'h0;
        step();
        bus_write(BASE + 8'd1, 8'h0F);
        src_irq = 4'b1010;
        step();
        step();
        bus_read("prio_first", BASE + 8'd2, 8'h01);
        service();
        chk("prio_ack1", 8'(src_ack), 8'h02);
        chk("prio_gap", 8'(bus.cpu_irq), 8'h00);
        step();
        chk("prio_second_irq", 8'(bus.cpu_irq), 8'h01);
        bus_read("prio_second", BASE + 8'd2, 8'h03);
        service();
        chk("prio_ack3", 8'(src_ack), 8'h08);
        src_irq = 4'h0;
        step();
        src_irq = 4'b0010;
        step();
        step();
        service();
        src_irq = 4'b0101;
        step();
        step();
`ifdef INTC_ROUND_ROBIN_EN
        bus_read("rr_order", BASE + 8'd2, 8'h02);
`else
        bus_read("fixed_order", BASE + 8'd2, 8'h00);
`endif
        service();
        step();
        service();
        src_irq = 4'h0;
        step();
        bus_write(BASE + 8'd1, 8'h00);
        src_irq = 4'b0100;
        bus_write(BASE, 8'h04);
        bus_read("w1c_collision", BASE, 8'h04);
        bus_write(BASE, 8'h04);
        bus_read("w1c_cleared", BASE, 8'h00);
        src_irq = 4'h0;
        step();
        bus_write(BASE + 8'd1, 8'h02);
        src_irq = 4'b0010;
        step();
        step();
        chk("held_irq", 8'(bus.cpu_irq), 8'h01);
        service();
        chk("held_ack", 8'(src_ack), 8'h02);
        repeat (4) begin
            step();
            chk("held_no_reirq", 8'(bus.cpu_irq), 8'h00);
        end
        bus_read("held_pending", BASE, 8'h00);
        src_irq = 4'h0;
        step();
        src_irq = 4'b0010;
        step();
        step();
        chk("held_rearm", 8'(bus.cpu_irq), 8'h01);
        bus.addr = BASE + 8'd2;
        step();
        bus.addr = 8'h00;
        bus.cpu_irq_ack = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("midreq_reset_irq", 8'(bus.cpu_irq), 8'h00);
        chk("midreq_reset_ack", 8'(src_ack), 8'h00);
        chk("midreq_reset_oe", 8'(dut.rd_oe), 8'h00);
        @(posedge clk);
        #1;
        chk("midreq_no_ack_pulse", 8'(src_ack), 8'h00);
        model_reset();
        rst_n = 1'b1;
        bus.cpu_irq_ack = 1'b0;
        bus_read("midreq_vector", BASE + 8'd2, 8'hFF);
        bus_read("midreq_mask", BASE + 8'd1, 8'h00);
        bus.cpu_irq_ack = 1'b1;
        step();
        step();
        bus.cpu_irq_ack = 1'b0;
        chk("idle_ack_ignored", 8'(src_ack), 8'h00);
        src_irq = 4'h0;
        bus_write(BASE, 8'h0F);
        bus_write(BASE + 8'd1, 8'h0F);
        for (int i = 0; i < 400; i++) begin
            src_irq = src_irq ^ 4'($urandom & $urandom);
            bus.cpu_irq_ack = 1'($urandom);
            case ($urandom_range(0, 9))
                0: bus_write(BASE + 8'd1, 8'($urandom));
                1: bus_write(BASE, 8'($urandom));
                2, 3: begin
                    bus.addr = BASE + 8'($urandom_range(0, 2));
                    step();
                    bus.addr = 8'h00;
                    step();
                end
                default: step();
            endcase
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/interrupt_controller.md
# interrupt_controller

Bus-mapped interrupt controller sitting directly downstream of the Timer and other interrupt-raising peripherals. It latches each peripheral's raise line into a pending register, gates it with a software mask, picks one source, and presents a single request to the Processor with a raise/ack handshake. It returns a one-cycle ack to the serviced peripheral and exposes PENDING, MASK and VECTOR registers on the shared 8-bit bus.

## Interface
- NUM_SRC, 4: number of interrupt sources, 1..8.
- BASE_ADDR, 8'hE0: bus base address; the block occupies BASE_ADDR..BASE_ADDR+2.

- CLK  in  1  system clock, rising edge.
- RESET  in  1  asynchronous, active-low reset.
- BUS_DATA  inout  8  shared data bus; driven only during a granted read, otherwise 8'hZZ.
- BUS_ADDR  in  8  bus address.
- BUS_WE  in  1  bus write enable.
- SRC_IRQ  in  NUM_SRC  per-peripheral BUS_INTERRUPT_RAISE inputs.
- SRC_ACK  out  NUM_SRC  per-peripheral BUS_INTERRUPT_ACK outputs; one-cycle pulses.
- CPU_IRQ  out  1  interrupt request to the Processor.
- CPU_IRQ_ACK  in  1  Processor acknowledge.

## Operation
- **Edge capture:** a registered copy of SRC_IRQ is kept. A rising edge on bit i sets PENDING[i]. A raise held high does not re-set PENDING after it is cleared.
- **Registers:**
  - BASE+0 PENDING: read returns PENDING; write-1-to-clear.
  - BASE+1 MASK: read/write; bit = 1 enables the source. Reset value 8'h00.
  - BASE+2 VECTOR: read-only; index of the source in service, 8'hFF when IDLE.
  - Bits at or above NUM_SRC read 0 and ignore writes.
- **FSM states:** IDLE, REQ.
  - **IDLE:** if (PENDING & MASK) != 0, select a source, latch its index into VECTOR, then go to REQ.
  - **REQ:** CPU_IRQ = 1. On CPU_IRQ_ACK = 1:
    - pulse SRC_ACK[VECTOR] for one cycle;
    - clear PENDING[VECTOR];
    - set VECTOR = 8'hFF;
    - return to IDLE.
- **Selection:** fixed priority by default; the lowest index wins.
- **Simultaneous events:**
  - A set and a clear on the same PENDING bit in the same cycle (W1C or ack): set wins.
  - Changing MASK during REQ does not abort the committed request.
  - CPU_IRQ_ACK in IDLE is ignored.
- **Reset (any time, including mid-REQ):**
  - PENDING, MASK and the edge register are cleared.
  - VECTOR = 8'hFF; state goes to IDLE.
  - CPU_IRQ = 0, SRC_ACK = 0, BUS_DATA = Z.

## Timing
- Source edge sampled at clock N: PENDING bit set after edge N, i.e. visible in cycle N+1.
- If IDLE and enabled: CPU_IRQ and VECTOR are valid in cycle N+2. Raise-to-request latency is 2 cycles.
- CPU_IRQ_ACK sampled high at edge M:
  - cycle M+1: CPU_IRQ = 0, SRC_ACK pulse high, PENDING bit clear;
  - cycle M+2 at the earliest: the next CPU_IRQ.
- Bus write: takes effect at the sampling edge. PENDING/MASK show the new value the following cycle.
- Bus read:
  - address decoded with BUS_WE = 0 at edge K;
  - data and output enable are registered, so BUS_DATA is driven during cycle K+1 only and released at edge K+2 unless the read continues.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- INTC_ROUND_ROBIN_EN
  - **Defined:** the search starts at (last serviced index + 1) mod NUM_SRC and wraps. A last-serviced register is added; it resets to NUM_SRC-1, so source 0 is first after reset.
  - **Undefined:** fixed lowest-index priority; no extra register.

## Test plan
- **Reset state:** hold RESET = 0 with SRC_IRQ = 4'hF, release, then read BASE+0/1/2 → 8'h00, 8'h00, 8'hFF. CPU_IRQ stays 0 with MASK = 0.
- **Timer path:**
  - write MASK = 8'h01, raise SRC_IRQ[0] at cycle N → CPU_IRQ = 1 in cycle N+2, VECTOR reads 8'h00;
  - ACK at edge M → SRC_ACK = 4'b0001 for exactly cycle M+1, PENDING = 8'h00, CPU_IRQ = 0.
- **Priority:**
  - MASK = 8'h0F, raise sources 3 and 1 in the same cycle → service order 1 then 3, with a 1-cycle gap between requests;
  - with INTC_ROUND_ROBIN_EN, after servicing 1, raise 0 and 2 together → 2 is serviced before 0.
- **W1C collision:** write 8'h04 to BASE+0 in the same cycle as an SRC_IRQ[2] rising edge → PENDING[2] stays 1.
- **Held raise:** keep SRC_IRQ[1] high through the ack → PENDING[1] = 0 afterwards and no second CPU_IRQ until SRC_IRQ[1] falls and rises again.
- **Reset mid-REQ:** assert RESET while CPU_IRQ = 1 → CPU_IRQ = 0 and VECTOR = 8'hFF asynchronously, no SRC_ACK pulse, BUS_DATA = Z.
